// File: rtl/trade_pkg.sv
// Shared types and defaults for the trade event emitter: FSM state encoding,
// default sizing constants and the saturating emitted-count increment.
package trade_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HIGH   = 2'd1,
      GAP    = 2'd2,
      HALTED = 2'd3
   } emit_state_e;

   localparam int MAX_TRADES          = 99;
   localparam int DEFAULT_DEPTH       = 15;
   localparam int DEFAULT_HIGH_CYCLES = 2;
   localparam int DEFAULT_GAP_CYCLES  = 2;
   localparam int EMIT_CNT_W          = 8;
   localparam int TIMER_W             = 8;

   // Holds at all-ones so the emitted count never wraps back to zero.
   function automatic logic [EMIT_CNT_W-1:0] satInc(input logic [EMIT_CNT_W-1:0] value);
      logic [EMIT_CNT_W-1:0] result;
      result = value;
      if (value != {EMIT_CNT_W{1'b1}}) begin
         result = value + 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/emit_pulse_timer.sv
// Loadable down-counter; done_o is high once the count has reached zero, so a
// load of N-1 on entry to a state yields done_o in that state's N-th cycle.
module emit_pulse_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic [W-1:0] load_value_i,
   output logic         done_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_value_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/trade_event_emitter.sv
// Queues one-cycle match pulses and replays each as a clean enable_count pulse
// with a guaranteed low gap. Optional macro TRADE_EMIT_FLUSH_ON_HALT_EN flushes pending on halt.
module trade_event_emitter
   import trade_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
   parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
   localparam int PEND_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  match_signal_i,
   input  logic                  halt_signal_i,
   output logic                  enable_count_o,
   output logic [PEND_W-1:0]     pending_o,
   output logic [EMIT_CNT_W-1:0] emitted_count_o,
   output logic                  overflow_o,
   output logic                  busy_o
);

   localparam logic [PEND_W-1:0]  DEPTH_P   = PEND_W'(DEPTH);
   localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

   emit_state_e           state_q;
   emit_state_e           state_d;
   logic                  enable_q;
   logic                  enable_d;
   logic [PEND_W-1:0]     pending_q;
   logic [PEND_W-1:0]     pending_d;
   logic [EMIT_CNT_W-1:0] emitted_q;
   logic [EMIT_CNT_W-1:0] emitted_d;
   logic                  overflow_q;
   logic                  overflow_d;

   logic                  deq;
   logic                  full;
   logic                  accept;
   logic                  drop;
   logic                  timerLoad;
   logic [TIMER_W-1:0]    timerLoadValue;
   logic                  timerDone;
`ifdef TRADE_EMIT_FLUSH_ON_HALT_EN
   logic                  enterHalt;
`endif

   emit_pulse_timer #(
      .W(TIMER_W)
   ) u_timer (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (timerLoad),
      .load_value_i (timerLoadValue),
      .done_o       (timerDone)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         enable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
      end
   end

   // Halt is only honoured at pulse boundaries so a started pulse always completes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (halt_signal_i) begin
               state_d = HALTED;
            end else if (pending_q != '0) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (timerDone) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (timerDone) begin
               state_d = halt_signal_i ? HALTED : IDLE;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      deq            = (state_q == IDLE) && (state_d == HIGH);
      enable_d       = (state_d == HIGH);
      timerLoad      = 1'b0;
      timerLoadValue = '0;
      if (deq) begin
         timerLoad      = 1'b1;
         timerLoadValue = HIGH_LOAD;
      end else if ((state_q == HIGH) && (state_d == GAP)) begin
         timerLoad      = 1'b1;
         timerLoadValue = GAP_LOAD;
      end
`ifdef TRADE_EMIT_FLUSH_ON_HALT_EN
      enterHalt = (state_q != HALTED) && (state_d == HALTED);
`endif
   end

   // A full queue still takes a match when a dequeue frees a slot on the same edge.
   always_comb begin
      full       = (pending_q == DEPTH_P);
      accept     = match_signal_i && (!full || deq);
      drop       = match_signal_i && full && !deq;
      pending_d  = pending_q;
      if (accept && !deq) begin
         pending_d = pending_q + 1'b1;
      end else if (deq && !accept) begin
         pending_d = pending_q - 1'b1;
      end
`ifdef TRADE_EMIT_FLUSH_ON_HALT_EN
      if (enterHalt) begin
         pending_d = '0;
      end
`endif
      overflow_d = overflow_q | drop;
      emitted_d  = deq ? satInc(emitted_q) : emitted_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pending_q  <= '0;
         emitted_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         emitted_q  <= emitted_d;
         overflow_q <= overflow_d;
      end
   end

   assign enable_count_o  = enable_q;
   assign pending_o       = pending_q;
   assign emitted_count_o = emitted_q;
   assign overflow_o      = overflow_q;
   assign busy_o          = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_trade_event_emitter.sv
// Directed self-checking bench for trade_event_emitter with default parameters
// (DEPTH=15, HIGH=2, GAP=2); expected values are hand-derived cycle counts.
module tb_trade_event_emitter;

   logic       clk = 1'b0;
   logic       reset;
   logic       matchSig;
   logic       haltSig;
   logic       enableCount;
   logic [3:0] pending;
   logic [7:0] emittedCount;
   logic       overflow;
   logic       busy;

   int vectorCount = 0;
   int missCount   = 0;

   always #5 clk = ~clk;

   trade_event_emitter dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .match_signal_i  (matchSig),
      .halt_signal_i   (haltSig),
      .enable_count_o  (enableCount),
      .pending_o       (pending),
      .emitted_count_o (emittedCount),
      .overflow_o      (overflow),
      .busy_o          (busy)
   );

   // Drives one cycle's inputs, then samples just after the closing edge.
   task automatic applyStimulus(input logic m, input logic h);
      matchSig = m;
      haltSig  = h;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      int edges[8];
      int edgeCount;
      int peak;
      int prevEnable;
      int prevEmit;
      int wrapSeen;
      int cyc;
      int expPend;

      reset    = 1'b1;
      matchSig = 1'b0;
      haltSig  = 1'b0;
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      checkOutput("reset_enable",   enableCount,  0);
      checkOutput("reset_pending",  pending,      0);
      checkOutput("reset_emitted",  emittedCount, 0);
      checkOutput("reset_overflow", overflow,     0);
      checkOutput("reset_busy",     busy,         0);
      reset = 1'b0;

      $display("[TB] single match latency");
      applyStimulus(1, 0);
      checkOutput("single_c1_pending", pending, 1);
      checkOutput("single_c1_enable",  enableCount, 0);
      applyStimulus(0, 0);
      checkOutput("single_c2_enable",  enableCount, 1);
      checkOutput("single_c2_pending", pending, 0);
      checkOutput("single_c2_emitted", emittedCount, 1);
      applyStimulus(0, 0);
      checkOutput("single_c3_enable",  enableCount, 1);
      applyStimulus(0, 0);
      checkOutput("single_c4_enable",  enableCount, 0);
      applyStimulus(0, 0);
      checkOutput("single_c5_busy",    busy, 1);
      applyStimulus(0, 0);
      checkOutput("single_c6_busy",    busy, 0);

      $display("[TB] five back-to-back matches");
      edgeCount  = 0;
      peak       = 0;
      prevEnable = 0;
      for (int c = 0; c < 35; c++) begin
         applyStimulus(c < 5, 0);
         if (enableCount && !prevEnable && edgeCount < 8) begin
            edges[edgeCount] = c + 1;
            edgeCount++;
         end
         if (int'(pending) > peak) peak = int'(pending);
         prevEnable = int'(enableCount);
      end
      checkOutput("burst5_edges", edgeCount, 5);
      checkOutput("burst5_first_edge", edges[0], 2);
      for (int k = 1; k < 5; k++) begin
         checkOutput($sformatf("burst5_spacing%0d", k), edges[k] - edges[k-1], 5);
      end
      checkOutput("burst5_peak",     peak, 4);
      checkOutput("burst5_overflow", overflow, 0);
      checkOutput("burst5_emitted",  emittedCount, 6);
      checkOutput("burst5_pending",  pending, 0);

      $display("[TB] twenty matches into depth 15");
      for (int c = 0; c < 110; c++) begin
         applyStimulus(c < 20, 0);
         cyc = c + 1;
         if (cyc == 19) begin
            checkOutput("fill_c19_pending",  pending, 15);
            checkOutput("fill_c19_overflow", overflow, 0);
         end
         if (cyc == 20) begin
            checkOutput("fill_c20_pending",  pending, 15);
            checkOutput("fill_c20_overflow", overflow, 1);
         end
      end
      checkOutput("fill_emitted",  emittedCount, 25);
      checkOutput("fill_pending",  pending, 0);
      checkOutput("fill_overflow", overflow, 1);
      checkOutput("fill_busy",     busy, 0);

      $display("[TB] 300 trades, saturation and enq/deq coincidence");
      peak     = 0;
      wrapSeen = 0;
      prevEmit = int'(emittedCount);
      for (int c = 0; c < 1510; c++) begin
         applyStimulus((c == 0) || (((c - 1) % 5 == 0) && (c <= 1491)), 0);
         cyc = c + 1;
         if (int'(pending) > peak) peak = int'(pending);
         if (int'(emittedCount) < prevEmit) wrapSeen = 1;
         prevEmit = int'(emittedCount);
         if (cyc == 2)    checkOutput("sat_c2_pending", pending, 1);
         if (cyc == 1146) checkOutput("sat_c1146_emitted", emittedCount, 254);
         if (cyc == 1147) checkOutput("sat_c1147_emitted", emittedCount, 255);
         if (cyc == 1492) checkOutput("sat_c1492_pending", pending, 1);
      end
      checkOutput("sat_peak",    peak, 1);
      checkOutput("sat_no_wrap", wrapSeen, 0);
      checkOutput("sat_emitted", emittedCount, 255);
      checkOutput("sat_pending", pending, 0);

      $display("[TB] async reset mid-pulse");
      for (int c = 0; c < 7; c++) begin
         applyStimulus(c < 5, 0);
      end
      checkOutput("arst_pre_pending", pending, 3);
      checkOutput("arst_pre_enable",  enableCount, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_enable",   enableCount, 0);
      checkOutput("arst_pending",  pending, 0);
      checkOutput("arst_emitted",  emittedCount, 0);
      checkOutput("arst_overflow", overflow, 0);
      checkOutput("arst_busy",     busy, 0);
      applyStimulus(0, 0);
      reset = 1'b0;

      $display("[TB] halt during first HIGH cycle");
      for (int c = 0; c < 7; c++) begin
         applyStimulus(c < 4, 0);
      end
      checkOutput("halt_c7_pending", pending, 2);
      checkOutput("halt_c7_enable",  enableCount, 1);
      edgeCount  = 0;
      prevEnable = int'(enableCount);
`ifdef TRADE_EMIT_FLUSH_ON_HALT_EN
      expPend = 0;
`else
      expPend = 2;
`endif
      for (int c = 7; c < 40; c++) begin
         applyStimulus(c == 25, 1);
         cyc = c + 1;
         if (enableCount && !prevEnable) edgeCount++;
         prevEnable = int'(enableCount);
         if (cyc == 8)  checkOutput("halt_c8_enable", enableCount, 1);
         if (cyc == 9)  checkOutput("halt_c9_enable", enableCount, 0);
         if (cyc == 11) checkOutput("halt_c11_pending", pending, expPend);
      end
      checkOutput("halt_new_edges",   edgeCount, 0);
      checkOutput("halt_emitted",     emittedCount, 2);
      checkOutput("halt_pending_enq", pending, expPend + 1);
      checkOutput("halt_enable",      enableCount, 0);
      checkOutput("halt_busy",        busy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
